// File: rtl/wca_rbus_pkg.sv
// Shared rbus definitions: control-vector bit positions, widths and the
// decoded-qualifier struct used by every register hanging off the bus.
package wca_rbus_pkg;

  localparam int RBUS_CLK     = 0;
  localparam int RBUS_STB     = 1;
  localparam int RBUS_WE      = 2;
  localparam int RBUS_RE      = 3;
  localparam int RBUS_ADDR_LO = 4;
  localparam int RBUS_ADDR_HI = 11;

  localparam int RBUS_CTRL_W  = 12;
  localparam int RBUS_ADDR_W  = RBUS_ADDR_HI - RBUS_ADDR_LO + 1;
  localparam int RBUS_DATA_W  = 8;
  localparam int DWORD_W      = 32;

  typedef logic [RBUS_ADDR_W-1:0] rbus_addr_t;
  typedef logic [RBUS_DATA_W-1:0] rbus_byte_t;
  typedef logic [DWORD_W-1:0]     dword_t;
  typedef logic [1:0]             byte_sel_t;

  // Per-cycle bus qualification for one register address.
  typedef struct packed {
    logic addr_valid;
    logic rd;
    logic wr;
    logic stb;
  } rbus_qual_t;

  // Byte lane idx of a dword, lane 0 = bits [7:0].
  function automatic rbus_byte_t dword_byte(input dword_t v, input byte_sel_t idx);
    return v[RBUS_DATA_W*idx +: RBUS_DATA_W];
  endfunction

endpackage

// File: rtl/wca_rbus_decode.sv
// Address compare and read/write/strobe qualification for one rbus register.
// Purely combinational so every register sees its qualifiers in the same cycle.
module wca_rbus_decode
  import wca_rbus_pkg::*;
#(
  parameter rbus_addr_t MY_ADDR = 8'h00
) (
  input  rbus_addr_t addr,
  input  logic       read_enable,
  input  logic       write_enable,
  input  logic       data_strobe,
  output rbus_qual_t qual
);

  // Strobe is only meaningful for a selected register; a read strobe requires readEnable.
  always_comb begin
    qual            = '0;
    qual.addr_valid = (addr == MY_ADDR);
    qual.rd         = qual.addr_valid & read_enable;
    qual.wr         = qual.addr_valid & write_enable;
    qual.stb        = qual.rd & data_strobe;
  end

endmodule

// File: rtl/wca_read_dword_reg.sv
// 32-bit readback register on the 8-bit rbus, read as four byte strobes LSB first.
// Byte 0 comes live from hold; the byte-0 strobe snapshots hold into shadow so
// bytes 1..3 of a sequence never tear. Updates arriving while a sequence is in
// flight park in a one-entry pending slot and drain when the sequence ends.
module wca_read_dword_reg
  import wca_rbus_pkg::*;
#(
  parameter rbus_addr_t MY_ADDR     = 8'h00,
  parameter dword_t     RESET_VALUE = 32'h0000_0000
) (
  input  logic                   reset,
  input  logic [RBUS_CTRL_W-1:0] rbusCtrl,
  inout  wire  [RBUS_DATA_W-1:0] rbusData,
  input  logic [DWORD_W-1:0]     in_data,
  input  logic                   in_valid,
  output logic                   read_done,
  output logic                   dropped
);

  logic       clkbus;
  rbus_qual_t qual;

  byte_sel_t  select;
  dword_t     hold;
  dword_t     shadow;
  dword_t     pending;
  logic       pending_v;

  byte_sel_t  select_nxt;
  logic       locked;
  logic       byte0_stb;
  logic       last_stb;
  logic       release_seq;
  rbus_byte_t rd_byte;
  logic       unused_wr;

  assign clkbus = rbusCtrl[RBUS_CLK];

  wca_rbus_decode #(
    .MY_ADDR (MY_ADDR)
  ) u_decode (
    .addr         (rbusCtrl[RBUS_ADDR_HI:RBUS_ADDR_LO]),
    .read_enable  (rbusCtrl[RBUS_RE]),
    .write_enable (rbusCtrl[RBUS_WE]),
    .data_strobe  (rbusCtrl[RBUS_STB]),
    .qual         (qual)
  );

  // This register is read-only; a write qualifier never affects it.
  assign unused_wr = qual.wr;

  // Sequence control: byte counter advance, lock, and end-of-sequence detection.
  always_comb begin
    locked      = (select != 2'd0);
    byte0_stb   = qual.stb & (select == 2'd0);
    last_stb    = qual.stb & (select == 2'd3);
    select_nxt  = select;
    if (!qual.addr_valid)
      select_nxt = 2'd0;
    else if (qual.stb)
      select_nxt = select + 2'd1;
    // Returning to 0 from a locked state: 4th strobe wrap or deselect mid-sequence.
    release_seq = locked & (select_nxt == 2'd0);
  end

  // Byte source: live hold for byte 0, frozen snapshot for bytes 1..3.
  always_comb begin
    rd_byte = dword_byte(hold, 2'd0);
    if (locked)
      rd_byte = dword_byte(shadow, select);
  end

  // Only drive while this register is addressed for reading.
  assign rbusData = qual.rd ? rd_byte : {RBUS_DATA_W{1'bz}};

  // Byte counter; reset or deselect abandons any sequence in progress.
  always_ff @(posedge clkbus) begin
    if (reset)
      select <= 2'd0;
    else
      select <= select_nxt;
  end

  // Snapshot taken on the byte-0 strobe, before any same-cycle update lands in hold.
  always_ff @(posedge clkbus) begin
    if (reset)
      shadow <= RESET_VALUE;
    else if (byte0_stb)
      shadow <= hold;
  end

  // hold / pending slot management, including the drain at end of sequence.
  always_ff @(posedge clkbus) begin
    if (reset) begin
      hold      <= RESET_VALUE;
      pending   <= RESET_VALUE;
      pending_v <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (release_seq) begin
        // Sequence ends this edge; fresh input beats the parked value.
        pending_v <= 1'b0;
        if (in_valid) begin
          hold    <= in_data;
          dropped <= pending_v;
        end else if (pending_v) begin
          hold    <= pending;
        end
      end else if (in_valid) begin
        if (locked || byte0_stb) begin
          // Defer; the newest value replaces any older parked one.
          pending   <= in_data;
          pending_v <= 1'b1;
          dropped   <= pending_v;
        end else begin
          hold <= in_data;
        end
      end
    end
  end

  // One-cycle completion pulse after the 4th byte strobe.
  always_ff @(posedge clkbus) begin
    if (reset)
      read_done <= 1'b0;
    else
      read_done <= last_stb;
  end

endmodule
